seq_detect_param: RTL and testbench

//  Parametrised serial bit-pattern detector, successor to the fixed-sequence detector.

---
 rtl/seq_detect_pkg.sv | 12 +
 rtl/seq_detect_param_hist.sv | 41 ++++
 rtl/seq_detect_param.sv | 68 ++++++
 tb/tb_seq_detect_param.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Fill counter must represent 0..PAT_W inclusive.
    function automatic int clog2_fill(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_param_hist.sv
// Valid-qualified history shift register with a saturating fill counter.
module seq_hist_reg
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             din,
    input  logic             drop,
    output logic [PAT_W-1:0] hist,
    output logic             full
);

    localparam int FW = clog2_fill(PAT_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
    localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

    logic [PAT_W-2:0] hist_q;
    logic [FW-1:0]    fill_q;

    // Outputs look ahead: the window and fill state once din is shifted in.
    assign hist = {hist_q, din};
    assign full = (fill_q >= FILL_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= hist[PAT_W-2:0];
            if (drop)
                fill_q <= '0;
            else if (fill_q != FILL_MAX)
                fill_q <= fill_q + FW'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Run-time loadable serial pattern detector with overlap mode and match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             pattern_load,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] hist;
    logic             full;
    logic             shift;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;

    // A load discards the bit offered in the same cycle.
    assign shift   = in_valid && !pattern_load;
    assign hit     = shift && full && (hist == pat_q);
    assign cnt_inc = match_cnt + CNT_W'(1);

    seq_hist_reg #(
        .PAT_W(PAT_W)
    ) u_hist (
        .clk  (clk),
        .rst  (rst),
        .clr  (pattern_load),
        .shift(shift),
        .din  (in),
        .drop (hit && !overlap_en),
        .hist (hist),
        .full (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= PAT_RST;
            out       <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            out <= hit;
            if (pattern_load)
                pat_q <= pattern_in;
            if (cnt_clr) begin
                match_cnt <= '0;
                cnt_sat   <= 1'b0;
            end else if (hit && (match_cnt != '1)) begin
                match_cnt <= cnt_inc;
                if (cnt_inc == '1)
                    cnt_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: directed scenarios plus random traffic vs a queue model.
module tb_seq_detect_param;

    localparam int PW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in;
    logic          in_valid;
    logic [PW-1:0] pattern_in;
    logic          pattern_load;
    logic          overlap_en;
    logic          cnt_clr;
    logic          out;
    logic [CW-1:0] match_cnt;
    logic          cnt_sat;

    always #5 clk = ~clk;

    seq_detect_param #(
        .PAT_W  (PW),
        .PAT_RST(4'b1011),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .in_valid    (in_valid),
        .pattern_in  (pattern_in),
        .pattern_load(pattern_load),
        .overlap_en  (overlap_en),
        .cnt_clr     (cnt_clr),
        .out         (out),
        .match_cnt   (match_cnt),
        .cnt_sat     (cnt_sat)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: bits consumed since the last restart, most recent last.
    bit            mq[$];
    logic [PW-1:0] mpat = 4'b1011;
    int            mcnt = 0;
    logic          mout = 1'b0;
    int            pulses = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    task automatic cyc(input logic r, input logic v, input logic b,
                       input logic ld, input logic [PW-1:0] pin,
                       input logic ov, input logic cl);
        logic hit;
        int   val;
        hit = 1'b0;
        rst = r; in_valid = v; in = b; pattern_load = ld;
        pattern_in = pin; overlap_en = ov; cnt_clr = cl;
        @(posedge clk);
        if (r) begin
            mpat = 4'b1011;
            mq.delete();
            mcnt = 0;
        end else begin
            if (ld) begin
                mpat = pin;
                mq.delete();
            end else if (v) begin
                mq.push_back(b);
                if (mq.size() > PW)
                    void'(mq.pop_front());
                if (mq.size() == PW) begin
                    val = 0;
                    foreach (mq[i]) val = val * 2 + int'(mq[i]);
                    hit = (val == int'(mpat));
                end
                if (hit && !ov)
                    mq.delete();
            end
            if (cl)
                mcnt = 0;
            else if (hit)
                mcnt++;
        end
        mout = hit;
        #1;
        if (out) pulses++;
        check("out", 32'(out), 32'(mout));
        check("cnt", 32'(match_cnt), (mcnt > 3) ? 32'd3 : 32'(mcnt));
        check("sat", 32'(cnt_sat), 32'(mcnt >= 3));
    endtask

    task automatic do_rst();
        cyc(1, 0, 0, 0, 0, 0, 0);
        pulses = 0;
    endtask

    // Feed n valid bits of 'bits', MSB first.
    task automatic feed(input logic [15:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--)
            cyc(0, 1, bits[i], 0, 0, ov, 0);
    endtask

    initial begin
        do_rst();
        check("rst_out", 32'(out), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_sat", 32'(cnt_sat), 32'd0);

        // overlap on: 1011011 hits twice
        feed(16'b1011011, 7, 1);
        check("t1_cnt", 32'(match_cnt), 32'd2);
        check("t1_pulses", 32'(pulses), 32'd2);

        do_rst();
        feed(16'b1011011, 7, 0);
        check("t2_cnt", 32'(match_cnt), 32'd1);
        check("t2_pulses", 32'(pulses), 32'd1);

        // valid gaps between bits
        do_rst();
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] s;
            s = 4'b1011;
            cyc(0, 1, s[i], 0, 0, 1, 0);
            repeat ($urandom_range(1, 3)) cyc(0, 0, 1, 0, 0, 1, 0);
        end
        check("t3_pulses", 32'(pulses), 32'd1);

        // load mid-stream, offered bit discarded
        do_rst();
        feed(16'b10, 2, 1);
        cyc(0, 1, 1, 1, 4'b0110, 1, 0);
        feed(16'b0110, 4, 1);
        check("t4_cnt", 32'(match_cnt), 32'd1);

        // saturation, then clear coinciding with a hit
        do_rst();
        cyc(0, 0, 0, 1, 4'b1111, 1, 0);
        feed(16'hff, 8, 1);
        check("t5_pulses", 32'(pulses), 32'd5);
        check("t5_cnt", 32'(match_cnt), 32'd3);
        check("t5_sat", 32'(cnt_sat), 32'd1);
        cyc(0, 1, 1, 0, 0, 1, 1);
        check("t5_clr_out", 32'(out), 32'd1);
        check("t5_clr_cnt", 32'(match_cnt), 32'd0);
        check("t5_clr_sat", 32'(cnt_sat), 32'd0);

        // reset mid-stream
        feed(16'b101, 3, 1);
        do_rst();
        check("t6_rst_out", 32'(out), 32'd0);
        feed(16'b1011, 4, 1);
        check("t6_cnt", 32'(match_cnt), 32'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom),
                ($urandom_range(0, 39) == 0),
                4'($urandom),
                1'($urandom),
                ($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
